// File: rtl/dualram_tdp_pkg.sv
// Shared defaults and types for the true dual-port RAM.
// Imported by the init sequencer and the top level.
package dualram_tdp_pkg;

    localparam int W = 16;
    localparam int M = 64;

    localparam int RDW_READ_FIRST = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int INIT_VAL_DEF = 1;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } init_state_e;

endpackage

// File: rtl/dualram_init_seq.sv
// Post-reset fill sequencer: walks every address once with INIT_VAL.
// Holds busy high until the last word has been written.
module dualram_init_seq
    import dualram_tdp_pkg::*;
#(
    parameter int DW = W,
    parameter int DEPTH = M,
    parameter logic [DW-1:0] INIT_VAL = DW'(INIT_VAL_DEF),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_data
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    init_state_e state, state_nx;
    logic [AW-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            ptr <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT)
                ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT:  if (ptr == LAST) state_nx = S_READY;
            S_READY: state_nx = S_READY;
            default: state_nx = S_INIT;
        endcase
    end

    always_comb begin
        busy = (state == S_INIT);
        init_we = (state == S_INIT);
        init_addr = ptr;
        init_data = INIT_VAL;
    end

endmodule

// File: rtl/dualram_tdp.sv
// True dual-port RAM with init fill, X-priority write arbitration,
// selectable read-during-write and optional output register.
module dualram_tdp
    import dualram_tdp_pkg::*;
#(
    parameter int DW = W,
    parameter int DEPTH = M,
    parameter logic [DW-1:0] INIT_VAL = DW'(INIT_VAL_DEF),
    parameter int RDW_MODE = RDW_READ_FIRST,
    parameter int OUT_REG = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_x,
    input  logic          we_x,
    input  logic [AW-1:0] addr_x,
    input  logic [DW-1:0] data_x,
    output logic [DW-1:0] q_x,
    output logic          valid_x,
    input  logic          en_y,
    input  logic          we_y,
    input  logic [AW-1:0] addr_y,
    input  logic [DW-1:0] data_y,
    output logic [DW-1:0] q_y,
    output logic          valid_y,
    output logic          busy,
    output logic          collision
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam bit WF = (RDW_MODE == RDW_WRITE_FIRST);

    logic [DW-1:0] ram [DEPTH];

    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_data;

    dualram_init_seq #(
        .DW(DW),
        .DEPTH(DEPTH),
        .INIT_VAL(INIT_VAL)
    ) u_init (
        .clk(clk),
        .rst(rst),
        .busy(busy),
        .init_we(init_we),
        .init_addr(init_addr),
        .init_data(init_data)
    );

    logic acc, in_x, in_y, coll;
    logic [1:0] rd, wr;
    logic mw_x, mw_y;
    logic [AW-1:0] ma_x;
    logic [DW-1:0] md_x;
    logic [DW-1:0] rdat [2];
    logic [DW-1:0] wdat [2];

    assign acc = !rst && !busy;
    assign in_x = {1'b0, addr_x} < DEPTH_W;
    assign in_y = {1'b0, addr_y} < DEPTH_W;

    assign wr[0] = acc && en_x && we_x;
    assign wr[1] = acc && en_y && we_y;
    assign rd[0] = acc && en_x && !we_x;
    assign rd[1] = acc && en_y && !we_y;
    assign coll = wr[0] && wr[1] && (addr_x == addr_y);

    // Init fill borrows port X's write path while busy.
    assign mw_x = busy ? (init_we && !rst) : (wr[0] && in_x);
    assign ma_x = busy ? init_addr : addr_x;
    assign md_x = busy ? init_data : data_x;
    assign mw_y = wr[1] && in_y && !coll;

    always_ff @(posedge clk) begin
        if (mw_x) ram[ma_x] <= md_x;
        if (mw_y) ram[addr_y] <= data_y;
    end

    assign rdat[0] = in_x ? ram[addr_x] : '0;
    assign rdat[1] = in_y ? ram[addr_y] : '0;
    assign wdat[0] = data_x;
    assign wdat[1] = data_y;

    logic [DW-1:0] d1 [2];
    logic [DW-1:0] d2 [2];
    logic [1:0] v1, v2, ld1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= '0;
            v2 <= '0;
            ld1 <= '0;
            collision <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                d1[p] <= '0;
                d2[p] <= '0;
            end
        end else begin
            collision <= coll;
            for (int p = 0; p < 2; p++) begin
                v1[p] <= rd[p];
                ld1[p] <= rd[p] || (wr[p] && WF);
                if (rd[p])
                    d1[p] <= rdat[p];
                else if (wr[p] && WF)
                    d1[p] <= wdat[p];
                v2[p] <= v1[p];
                if (ld1[p])
                    d2[p] <= d1[p];
            end
        end
    end

    assign q_x = (OUT_REG != 0) ? d2[0] : d1[0];
    assign q_y = (OUT_REG != 0) ? d2[1] : d1[1];
    assign valid_x = (OUT_REG != 0) ? v2[0] : v1[0];
    assign valid_y = (OUT_REG != 0) ? v2[1] : v1[1];

endmodule

// File: tb/tb_dualram_tdp.sv
// Directed bench: three configurations driven by one shared stimulus.
// A: 64/write-first/lat1, B: 64/read-first/lat2, C: 48/read-first/lat1.
module tb_dualram_tdp;

    localparam int DW = 16;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_x = 1'b0, we_x = 1'b0, en_y = 1'b0, we_y = 1'b0;
    logic [AW-1:0] addr_x = '0, addr_y = '0;
    logic [DW-1:0] data_x = '0, data_y = '0;

    logic [DW-1:0] qa_x, qa_y, qb_x, qb_y, qc_x, qc_y;
    logic va_x, va_y, vb_x, vb_y, vc_x, vc_y;
    logic busy_a, busy_b, busy_c, col_a, col_b, col_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dualram_tdp #(.DW(16), .DEPTH(64), .RDW_MODE(1), .OUT_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .en_x(en_x), .we_x(we_x), .addr_x(addr_x), .data_x(data_x),
        .q_x(qa_x), .valid_x(va_x),
        .en_y(en_y), .we_y(we_y), .addr_y(addr_y), .data_y(data_y),
        .q_y(qa_y), .valid_y(va_y),
        .busy(busy_a), .collision(col_a)
    );

    dualram_tdp #(.DW(16), .DEPTH(64), .RDW_MODE(0), .OUT_REG(1)) u_b (
        .clk(clk), .rst(rst),
        .en_x(en_x), .we_x(we_x), .addr_x(addr_x), .data_x(data_x),
        .q_x(qb_x), .valid_x(vb_x),
        .en_y(en_y), .we_y(we_y), .addr_y(addr_y), .data_y(data_y),
        .q_y(qb_y), .valid_y(vb_y),
        .busy(busy_b), .collision(col_b)
    );

    dualram_tdp #(.DW(16), .DEPTH(48), .RDW_MODE(0), .OUT_REG(0)) u_c (
        .clk(clk), .rst(rst),
        .en_x(en_x), .we_x(we_x), .addr_x(addr_x), .data_x(data_x),
        .q_x(qc_x), .valid_x(vc_x),
        .en_y(en_y), .we_y(we_y), .addr_y(addr_y), .data_y(data_y),
        .q_y(qc_y), .valid_y(vc_y),
        .busy(busy_c), .collision(col_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en_x = 1'b0; we_x = 1'b0; en_y = 1'b0; we_y = 1'b0;
    endtask

    task automatic px(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
        en_x = 1'b1; we_x = w; addr_x = a; data_x = d;
    endtask

    task automatic py(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
        en_y = 1'b1; we_y = w; addr_y = a; data_y = d;
    endtask

    int na, nc, nb, bad;

    initial begin
        // reset and init timing
        rst = 1'b1;
        step();
        chk("rst_q_x", 32'(qa_x), 32'h0);
        chk("rst_valid_x", 32'(va_x), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h1);
        chk("rst_collision", 32'(col_a), 32'h0);
        chk("rst_valid_y_b", 32'(vb_y), 32'h0);
        rst = 1'b0;
        na = 0; nc = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (!busy_a && na == 0) na = i;
            if (!busy_c && nc == 0) nc = i;
        end
        chk("init_len_64", 32'(na), 32'd64);
        chk("init_len_48", 32'(nc), 32'd48);

        // read back init values
        px(1'b0, 6'd0, '0);
        step();
        chk("a_rd0_q", 32'(qa_x), 32'h1);
        chk("a_rd0_v", 32'(va_x), 32'h1);
        chk("c_rd0_q", 32'(qc_x), 32'h1);
        chk("b_rd0_v_early", 32'(vb_x), 32'h0);
        px(1'b0, 6'd31, '0);
        step();
        chk("a_rd31_q", 32'(qa_x), 32'h1);
        chk("b_rd0_q", 32'(qb_x), 32'h1);
        chk("b_rd0_v", 32'(vb_x), 32'h1);
        px(1'b0, 6'd63, '0);
        step();
        chk("a_rd63_q", 32'(qa_x), 32'h1);
        chk("a_rd63_v", 32'(va_x), 32'h1);
        chk("c_rd63_oor_q", 32'(qc_x), 32'h0);
        chk("c_rd63_oor_v", 32'(vc_x), 32'h1);
        idle();
        step();
        chk("a_pulse_v", 32'(va_x), 32'h0);
        chk("a_hold_q", 32'(qa_x), 32'h1);

        // dual write, cross read
        px(1'b1, 6'd5, 16'h00AA);
        py(1'b1, 6'd9, 16'h0055);
        step();
        chk("a_wr_vx", 32'(va_x), 32'h0);
        chk("a_wr_vy", 32'(va_y), 32'h0);
        px(1'b0, 6'd9, '0);
        py(1'b0, 6'd5, '0);
        step();
        chk("a_rd9_q", 32'(qa_x), 32'h0055);
        chk("a_rd5_q", 32'(qa_y), 32'h00AA);
        chk("a_rd5_v", 32'(va_y), 32'h1);
        chk("b_lat2_early", 32'(vb_x), 32'h0);
        idle();
        step();
        chk("b_rd9_q", 32'(qb_x), 32'h0055);
        chk("b_rd9_v", 32'(vb_x), 32'h1);
        chk("b_rd5_q", 32'(qb_y), 32'h00AA);

        // read during write
        px(1'b1, 6'd3, 16'h1234);
        py(1'b0, 6'd3, '0);
        step();
        chk("a_cross_old_q", 32'(qa_y), 32'h0001);
        chk("a_cross_old_v", 32'(va_y), 32'h1);
        chk("a_wf_q", 32'(qa_x), 32'h1234);
        chk("a_wf_v", 32'(va_x), 32'h0);
        chk("c_rf_q", 32'(qc_x), 32'h0055);
        chk("c_rf_v", 32'(vc_x), 32'h0);
        px(1'b0, 6'd3, '0);
        idle();
        en_x = 1'b1;
        step();
        chk("a_rd3_q", 32'(qa_x), 32'h1234);

        // write-write collision
        px(1'b1, 6'd7, 16'h1111);
        py(1'b1, 6'd7, 16'h2222);
        step();
        chk("a_coll_set", 32'(col_a), 32'h1);
        idle();
        step();
        chk("a_coll_pulse", 32'(col_a), 32'h0);
        px(1'b0, 6'd7, '0);
        py(1'b0, 6'd7, '0);
        step();
        chk("a_coll_x_wins", 32'(qa_x), 32'h1111);
        chk("a_coll_y_rd", 32'(qa_y), 32'h1111);

        // boundary on the 48-word instance
        px(1'b1, 6'd47, 16'hBEEF);
        py(1'b1, 6'd50, 16'h7777);
        step();
        px(1'b0, 6'd47, '0);
        py(1'b0, 6'd50, '0);
        step();
        chk("c_rd47_q", 32'(qc_x), 32'hBEEF);
        chk("c_rd50_q", 32'(qc_y), 32'h0);
        chk("c_rd50_v", 32'(vc_y), 32'h1);
        chk("a_rd50_q", 32'(qa_y), 32'h7777);
        idle();

        // reset in the middle of init, with requests while busy
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("mid_busy", 32'(busy_a), 32'h1);
        rst = 1'b1;
        px(1'b1, 6'd5, 16'hDEAD);
        py(1'b0, 6'd9, '0);
        step();
        rst = 1'b0;
        nb = 0; bad = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (va_x || va_y || col_a) bad++;
            if (!busy_a) begin
                nb = i;
                idle();
                break;
            end
        end
        chk("reinit_len", 32'(nb), 32'd64);
        chk("busy_no_valid", 32'(bad), 32'd0);
        px(1'b0, 6'd5, '0);
        py(1'b0, 6'd3, '0);
        step();
        chk("reinit_rd5", 32'(qa_x), 32'h1);
        chk("reinit_rd3", 32'(qa_y), 32'h1);
        px(1'b0, 6'd7, '0);
        idle();
        en_x = 1'b1;
        step();
        chk("reinit_rd7", 32'(qa_x), 32'h1);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
